dutb_result_tracker: RTL and testbench
======================================

Name: dutb_result_tracker

Overview:
Synthesizable scoreboard-side tracker that consumes per-transaction pass/fail verdicts from the checker through a valid/ready handshake. It applies the testbench run-control policy in hardware:
- post-reset warm-up window;
- pass/fail/total counting;
- milestone pulses that drive the progress bar;
- sticky stop request once the failure limit is hit;
- done flag when an expected item count is reached.

It sits directly downstream of the checker and upstream of the TB control/reporting logic.

Parameters:
P_RSTN_LENGTH, 33, warm-up cycles after reset/clear during which no verdicts are accepted
P_MAX_FAIL_NUM, 16, fail count that triggers stop; 0 = never stop
P_MILESTONE_LENGTH, 10, accepted items per milestone pulse; 0 = milestones disabled
P_CNT_W, 32, width of all counters and of cfg_total

Ports:
clk  in  1  single clock; all logic rising-edge
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous restart pulse: zero counters, re-enter warm-up
cfg_total  in  P_CNT_W  expected item count, sampled continuously; 0 = unlimited
res_valid  in  1  verdict valid
res_pass  in  1  verdict: 1 = pass, 0 = fail
res_ready  out  1  tracker accepts verdict this cycle
pass_cnt  out  P_CNT_W  accepted passing items
fail_cnt  out  P_CNT_W  accepted failing items
total_cnt  out  P_CNT_W  pass_cnt + fail_cnt
milestone  out  1  one-cycle pulse per P_MILESTONE_LENGTH accepted items
milestone_idx  out  P_CNT_W  number of milestones reached
stop_req  out  1  sticky: fail limit reached
done  out  1  sticky: total_cnt reached nonzero cfg_total
busy  out  1  high in WARMUP or RUN

Behaviour:
- Asynchronous reset (rst high): state=WARMUP, warm-up counter=0, all counters 0, milestone=0, stop_req=0, done=0, res_ready=0.
- Accept condition: res_valid & res_ready. res_ready is a registered function of state; it is 1 only in RUN.
- States and transitions:
  - WARMUP: counts cycles. After exactly P_RSTN_LENGTH cycles -> RUN. The first cycle with res_ready=1 is cycle P_RSTN_LENGTH+1 after rst deasserts. If P_RSTN_LENGTH=0, the next cycle enters RUN.
  - RUN: each accept increments total_cnt, plus pass_cnt or fail_cnt, with counters visible the next cycle.
    - -> STOP when post-accept fail_cnt == P_MAX_FAIL_NUM (≠0); stop_req=1 in the same cycle as the count update.
    - -> DONE when post-accept total_cnt == cfg_total (≠0); done=1 in the same cycle.
  - STOP, DONE: terminal. res_ready=0, counters frozen. Only clear or rst exits.
- Simultaneous stop and done on the same accept: go to STOP; stop_req=1 and done=1 both set.
- Milestone: registered pulse in the cycle after the accept that makes total_cnt a multiple of P_MILESTONE_LENGTH; milestone_idx increments in that same cycle.
  - Use a modulo counter, not a divider.
  - A milestone coinciding with STOP/DONE is still emitted.
- Counters saturate at 2^P_CNT_W-1 and never wrap. A saturated total_cnt cannot trigger done.
- cfg_total changed in RUN to a value ≤ current total_cnt: done is not asserted; it asserts only on exact equality at an accept.
- clear (any state, priority over accept): next cycle counters=0, milestone_idx=0, stop_req=0, done=0, milestone=0, state=WARMUP with the warm-up counter restarted. A verdict presented in the clear cycle is dropped, not counted.
- rst asserted mid-RUN: immediate return to reset values, independent of clk.
- res_valid held with res_ready=0: verdict is not counted. The producer holds it per the standard valid/ready rule.

Test Plan:
- Reset release, res_valid=1 constantly, P_RSTN_LENGTH=33 -> res_ready=0 for 33 cycles, first accept on cycle 34, busy=1 throughout.
- 25 passing verdicts back-to-back, cfg_total=0 -> pass_cnt=25, fail_cnt=0, milestone pulses after items 10 and 20, milestone_idx=2, no done/stop.
- Alternating pass/fail, P_MAX_FAIL_NUM=16 -> stop_req=1 at accept of item 32, fail_cnt=16, pass_cnt=16, res_ready=0 thereafter, further valids ignored.
- cfg_total=20, 19 passes then 1 fail with P_MAX_FAIL_NUM=1 -> STOP wins, stop_req=1, done=1, total_cnt=20, milestone pulse for item 20.
- clear asserted mid-RUN at total_cnt=7 with res_valid=1 -> that verdict is not counted, all counters 0 next cycle, res_ready=0 for 33 cycles, then counting resumes from 0.
- P_CNT_W=4, 20 passes with P_RSTN_LENGTH=0 -> pass_cnt and total_cnt saturate at 15, milestone_idx=1, no wrap.

Source files
------------

// File: rtl/dutb_result_tracker.sv
// Result tracker: accepts pass/fail verdicts after a warm-up window, counts them,
// emits milestone pulses and raises sticky stop/done run-control flags.
module dutb_result_tracker #(
    parameter int unsigned P_RSTN_LENGTH      = 33,
    parameter int unsigned P_MAX_FAIL_NUM     = 16,
    parameter int unsigned P_MILESTONE_LENGTH = 10,
    parameter int unsigned P_CNT_W            = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [P_CNT_W-1:0] cfg_total,
    input  logic               res_valid,
    input  logic               res_pass,
    output logic               res_ready,
    output logic [P_CNT_W-1:0] pass_cnt,
    output logic [P_CNT_W-1:0] fail_cnt,
    output logic [P_CNT_W-1:0] total_cnt,
    output logic               milestone,
    output logic [P_CNT_W-1:0] milestone_idx,
    output logic               stop_req,
    output logic               done,
    output logic               busy
);

    localparam int unsigned WU_W = (P_RSTN_LENGTH > 1) ? $clog2(P_RSTN_LENGTH) : 1;
    localparam int unsigned MS_W = (P_MILESTONE_LENGTH > 1) ? $clog2(P_MILESTONE_LENGTH) : 1;
    localparam logic [WU_W-1:0] WU_LAST =
        WU_W'((P_RSTN_LENGTH > 0) ? P_RSTN_LENGTH - 1 : 0);
    localparam logic [MS_W-1:0] MS_LAST =
        MS_W'((P_MILESTONE_LENGTH > 0) ? P_MILESTONE_LENGTH - 1 : 0);

    typedef enum logic [1:0] {
        S_WARMUP,
        S_RUN,
        S_STOP,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WU_W-1:0]    r_wu_cnt;
    logic [MS_W-1:0]    r_ms_mod;
    logic [P_CNT_W-1:0] r_pass;
    logic [P_CNT_W-1:0] r_fail;
    logic [P_CNT_W-1:0] r_total;
    logic [P_CNT_W-1:0] r_ms_idx;
    logic               r_ms;
    logic               r_stop;
    logic               r_done;

    logic               w_acc;
    logic               w_tot_inc;
    logic               w_wu_end;
    logic               w_stop_hit;
    logic               w_done_hit;
    logic               w_ms_hit;
    logic [P_CNT_W-1:0] w_pass_nxt;
    logic [P_CNT_W-1:0] w_fail_nxt;
    logic [P_CNT_W-1:0] w_tot_nxt;

    assign res_ready     = (r_state == S_RUN);
    assign busy          = (r_state == S_WARMUP) || (r_state == S_RUN);
    assign pass_cnt      = r_pass;
    assign fail_cnt      = r_fail;
    assign total_cnt     = r_total;
    assign milestone     = r_ms;
    assign milestone_idx = r_ms_idx;
    assign stop_req      = r_stop;
    assign done          = r_done;

    // clear wins over a verdict presented in the same cycle
    assign w_acc     = res_valid & res_ready & ~clear;
    assign w_tot_inc = w_acc & (r_total != '1);
    assign w_wu_end  = (P_RSTN_LENGTH == 0) || (r_wu_cnt == WU_LAST);

    assign w_pass_nxt = (w_acc && res_pass && r_pass != '1) ? r_pass + 1'b1 : r_pass;
    assign w_fail_nxt = (w_acc && !res_pass && r_fail != '1) ? r_fail + 1'b1 : r_fail;
    assign w_tot_nxt  = w_tot_inc ? r_total + 1'b1 : r_total;

    assign w_stop_hit = (P_MAX_FAIL_NUM != 0) && w_acc && !res_pass &&
                        (64'(w_fail_nxt) == 64'(P_MAX_FAIL_NUM));
    // a saturated total never increments, so it can never match cfg_total
    assign w_done_hit = w_tot_inc && (cfg_total != '0) && (w_tot_nxt == cfg_total);
    assign w_ms_hit   = (P_MILESTONE_LENGTH != 0) && w_tot_inc && (r_ms_mod == MS_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WARMUP: begin
                if (w_wu_end) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_stop_hit)      w_state_nxt = S_STOP;
                else if (w_done_hit) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = r_state;
        endcase
        if (clear) w_state_nxt = S_WARMUP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_WARMUP;
            r_wu_cnt <= '0;
            r_ms_mod <= '0;
            r_pass   <= '0;
            r_fail   <= '0;
            r_total  <= '0;
            r_ms_idx <= '0;
            r_ms     <= 1'b0;
            r_stop   <= 1'b0;
            r_done   <= 1'b0;
        end else if (clear) begin
            r_state  <= S_WARMUP;
            r_wu_cnt <= '0;
            r_ms_mod <= '0;
            r_pass   <= '0;
            r_fail   <= '0;
            r_total  <= '0;
            r_ms_idx <= '0;
            r_ms     <= 1'b0;
            r_stop   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_WARMUP && !w_wu_end) r_wu_cnt <= r_wu_cnt + 1'b1;
            else                                  r_wu_cnt <= '0;
            if (w_tot_inc) begin
                if (r_ms_mod == MS_LAST) r_ms_mod <= '0;
                else                     r_ms_mod <= r_ms_mod + 1'b1;
            end
            r_pass  <= w_pass_nxt;
            r_fail  <= w_fail_nxt;
            r_total <= w_tot_nxt;
            r_ms    <= w_ms_hit;
            if (w_ms_hit && r_ms_idx != '1) r_ms_idx <= r_ms_idx + 1'b1;
            r_stop  <= r_stop | w_stop_hit;
            r_done  <= r_done | w_done_hit;
        end
    end

endmodule

// File: tb/tb_dutb_result_tracker.sv
// Bench for dutb_result_tracker: three parameterisations driven in lockstep,
// checked against vector tables, hand sequences and an integer reference model.
module tb_dutb_result_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        res_valid;
    logic        res_pass;
    logic [31:0] cfg_total;

    logic        a_rdy, a_ms, a_stop, a_done, a_busy;
    logic [31:0] a_pass, a_fail, a_tot, a_idx;
    logic        b_rdy, b_ms, b_stop, b_done, b_busy;
    logic [31:0] b_pass, b_fail, b_tot, b_idx;
    logic        c_rdy, c_ms, c_stop, c_done, c_busy;
    logic [3:0]  c_pass, c_fail, c_tot, c_idx;

    always #5 clk = ~clk;

    dutb_result_tracker #(
        .P_RSTN_LENGTH(33), .P_MAX_FAIL_NUM(16),
        .P_MILESTONE_LENGTH(10), .P_CNT_W(32)
    ) u_a (
        .clk(clk), .rst(rst), .clear(clear), .cfg_total(cfg_total),
        .res_valid(res_valid), .res_pass(res_pass), .res_ready(a_rdy),
        .pass_cnt(a_pass), .fail_cnt(a_fail), .total_cnt(a_tot),
        .milestone(a_ms), .milestone_idx(a_idx), .stop_req(a_stop),
        .done(a_done), .busy(a_busy)
    );

    dutb_result_tracker #(
        .P_RSTN_LENGTH(0), .P_MAX_FAIL_NUM(1),
        .P_MILESTONE_LENGTH(10), .P_CNT_W(32)
    ) u_b (
        .clk(clk), .rst(rst), .clear(clear), .cfg_total(cfg_total),
        .res_valid(res_valid), .res_pass(res_pass), .res_ready(b_rdy),
        .pass_cnt(b_pass), .fail_cnt(b_fail), .total_cnt(b_tot),
        .milestone(b_ms), .milestone_idx(b_idx), .stop_req(b_stop),
        .done(b_done), .busy(b_busy)
    );

    dutb_result_tracker #(
        .P_RSTN_LENGTH(0), .P_MAX_FAIL_NUM(16),
        .P_MILESTONE_LENGTH(10), .P_CNT_W(4)
    ) u_c (
        .clk(clk), .rst(rst), .clear(clear), .cfg_total(cfg_total[3:0]),
        .res_valid(res_valid), .res_pass(res_pass), .res_ready(c_rdy),
        .pass_cnt(c_pass), .fail_cnt(c_fail), .total_cnt(c_tot),
        .milestone(c_ms), .milestone_idx(c_idx), .stop_req(c_stop),
        .done(c_done), .busy(c_busy)
    );

    typedef struct {
        logic        rdy, ms, stop, done, busy;
        logic [31:0] pass, fail, tot, idx;
    } obs_t;

    obs_t obs [3];

    always_comb begin
        obs[0] = '{a_rdy, a_ms, a_stop, a_done, a_busy, a_pass, a_fail, a_tot, a_idx};
        obs[1] = '{b_rdy, b_ms, b_stop, b_done, b_busy, b_pass, b_fail, b_tot, b_idx};
        obs[2] = '{c_rdy, c_ms, c_stop, c_done, c_busy,
                   32'(c_pass), 32'(c_fail), 32'(c_tot), 32'(c_idx)};
    end

    // reference model parameters, one entry per instance
    localparam int PR [3] = '{33, 0, 0};
    localparam int PM [3] = '{16, 1, 16};
    localparam int PL [3] = '{10, 10, 10};
    localparam int PW [3] = '{32, 32, 4};

    longint m_pass [3], m_fail [3], m_tot [3], m_idx [3], m_cyc [3];
    bit     m_ms [3], m_stop [3], m_done [3];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset(int i);
        m_pass[i] = 0; m_fail[i] = 0; m_tot[i] = 0; m_idx[i] = 0;
        m_cyc[i]  = 0; m_ms[i]   = 0; m_stop[i] = 0; m_done[i] = 0;
    endfunction

    // ready once enough edges have passed since reset/clear and not finished
    function automatic bit m_ready(int i);
        longint need = (PR[i] == 0) ? 1 : PR[i];
        return !m_stop[i] && !m_done[i] && (m_cyc[i] >= need);
    endfunction

    function automatic void m_step(int i);
        bit     rdy = m_ready(i);
        longint mx  = (longint'(1) << PW[i]) - 1;
        longint cfg = longint'(cfg_total) & mx;
        if (clear) begin
            m_reset(i);
            return;
        end
        m_ms[i] = 0;
        if (res_valid && rdy) begin
            if (res_pass) m_pass[i] = (m_pass[i] < mx) ? m_pass[i] + 1 : mx;
            else          m_fail[i] = (m_fail[i] < mx) ? m_fail[i] + 1 : mx;
            if (m_tot[i] < mx) begin
                m_tot[i]++;
                if (PL[i] != 0 && m_tot[i] % PL[i] == 0) begin
                    m_ms[i]  = 1;
                    m_idx[i] = (m_idx[i] < mx) ? m_idx[i] + 1 : mx;
                end
                if (cfg != 0 && m_tot[i] == cfg) m_done[i] = 1;
            end
            if (PM[i] != 0 && m_fail[i] == PM[i]) m_stop[i] = 1;
        end
        m_cyc[i]++;
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            cmp($sformatf("u%0d.ready", i), obs[i].rdy,  m_ready(i));
            cmp($sformatf("u%0d.pass", i),  obs[i].pass, m_pass[i]);
            cmp($sformatf("u%0d.fail", i),  obs[i].fail, m_fail[i]);
            cmp($sformatf("u%0d.total", i), obs[i].tot,  m_tot[i]);
            cmp($sformatf("u%0d.ms", i),    obs[i].ms,   m_ms[i]);
            cmp($sformatf("u%0d.ms_idx", i), obs[i].idx, m_idx[i]);
            cmp($sformatf("u%0d.stop", i),  obs[i].stop, m_stop[i]);
            cmp($sformatf("u%0d.done", i),  obs[i].done, m_done[i]);
            cmp($sformatf("u%0d.busy", i),  obs[i].busy, !m_stop[i] && !m_done[i]);
        end
    endtask

    task automatic tick();
        for (int i = 0; i < 3; i++) m_step(i);
        @(posedge clk);
        #1;
        check_all();
    endtask

    typedef struct {
        int n, v, mode, clr, cfg;
        int rdy, p, f, idx, stop, done, busy;
    } vec_t;

    vec_t vt [17];

    initial begin
        vt[0]  = '{32, 1, 0, 0, 0,  0, 0,  0,  0, 0, 0, 1};
        vt[1]  = '{1,  1, 0, 0, 0,  1, 0,  0,  0, 0, 0, 1};
        vt[2]  = '{25, 1, 0, 0, 0,  1, 25, 0,  2, 0, 0, 1};
        vt[3]  = '{1,  1, 0, 1, 0,  0, 0,  0,  0, 0, 0, 1};
        vt[4]  = '{33, 1, 0, 0, 0,  1, 0,  0,  0, 0, 0, 1};
        vt[5]  = '{7,  1, 0, 0, 0,  1, 7,  0,  0, 0, 0, 1};
        vt[6]  = '{1,  1, 0, 1, 0,  0, 0,  0,  0, 0, 0, 1};
        vt[7]  = '{33, 1, 0, 0, 0,  1, 0,  0,  0, 0, 0, 1};
        vt[8]  = '{32, 1, 1, 0, 0,  0, 16, 16, 3, 1, 0, 0};
        vt[9]  = '{5,  1, 1, 0, 0,  0, 16, 16, 3, 1, 0, 0};
        vt[10] = '{1,  1, 0, 1, 12, 0, 0,  0,  0, 0, 0, 1};
        vt[11] = '{33, 0, 0, 0, 12, 1, 0,  0,  0, 0, 0, 1};
        vt[12] = '{12, 1, 0, 0, 12, 0, 12, 0,  1, 0, 1, 0};
        vt[13] = '{1,  0, 0, 1, 0,  0, 0,  0,  0, 0, 0, 1};
        vt[14] = '{33, 0, 0, 0, 0,  1, 0,  0,  0, 0, 0, 1};
        vt[15] = '{8,  1, 0, 0, 0,  1, 8,  0,  0, 0, 0, 1};
        vt[16] = '{4,  1, 0, 0, 5,  1, 12, 0,  1, 0, 0, 1};

        rst = 1'b1; clear = 1'b0; res_valid = 1'b0; res_pass = 1'b0; cfg_total = '0;
        for (int i = 0; i < 3; i++) m_reset(i);
        #12;
        rst = 1'b0;
        res_valid = 1'b1; res_pass = 1'b1;
        check_all();

        // vector table against instance A
        for (int r = 0; r < 17; r++) begin
            for (int k = 0; k < vt[r].n; k++) begin
                clear     = vt[r].clr[0];
                res_valid = vt[r].v[0];
                res_pass  = (vt[r].mode == 0) ? 1'b1 :
                            (vt[r].mode == 1) ? (k % 2 == 0) : 1'b0;
                cfg_total = 32'(vt[r].cfg);
                tick();
            end
            clear = 1'b0;
            cmp($sformatf("vec%0d.ready", r), a_rdy,  vt[r].rdy);
            cmp($sformatf("vec%0d.pass", r),  a_pass, vt[r].p);
            cmp($sformatf("vec%0d.fail", r),  a_fail, vt[r].f);
            cmp($sformatf("vec%0d.total", r), a_tot,  vt[r].p + vt[r].f);
            cmp($sformatf("vec%0d.ms_idx", r), a_idx, vt[r].idx);
            cmp($sformatf("vec%0d.stop", r),  a_stop, vt[r].stop);
            cmp($sformatf("vec%0d.done", r),  a_done, vt[r].done);
            cmp($sformatf("vec%0d.busy", r),  a_busy, vt[r].busy);
        end

        // instance B: stop and done on the same accept
        clear = 1'b1; res_valid = 1'b1; res_pass = 1'b1; tick();
        clear = 1'b0; res_valid = 1'b0; cfg_total = 32'd20; tick();
        res_valid = 1'b1;
        for (int k = 0; k < 19; k++) tick();
        res_pass = 1'b0; tick();
        cmp("stopdone.stop",  b_stop, 1);
        cmp("stopdone.done",  b_done, 1);
        cmp("stopdone.total", b_tot,  20);
        cmp("stopdone.pass",  b_pass, 19);
        cmp("stopdone.fail",  b_fail, 1);
        cmp("stopdone.ms",    b_ms,   1);
        cmp("stopdone.idx",   b_idx,  2);
        cmp("stopdone.ready", b_rdy,  0);

        // instance C: 4-bit counters saturate without wrapping
        clear = 1'b1; res_pass = 1'b1; tick();
        clear = 1'b0; res_valid = 1'b0; cfg_total = '0; tick();
        res_valid = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        cmp("sat.pass",  c_pass, 15);
        cmp("sat.total", c_tot,  15);
        cmp("sat.idx",   c_idx,  1);
        cmp("sat.stop",  c_stop, 0);
        cmp("sat.done",  c_done, 0);
        cmp("sat.ready", c_rdy,  1);

        // randomized traffic against the model
        for (int r = 0; r < 6; r++) begin
            clear = 1'b1; tick();
            clear = 1'b0;
            cfg_total = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(20, 60));
            for (int k = 0; k < 120; k++) begin
                res_valid = ($urandom_range(0, 3) != 0);
                res_pass  = ($urandom_range(0, 7) != 0);
                clear     = ($urandom_range(0, 99) == 0);
                if (k == 70 && $urandom_range(0, 1) == 1)
                    cfg_total = 32'($urandom_range(0, 40));
                tick();
            end
            clear = 1'b0;
        end

        // asynchronous reset away from the clock edge
        rst = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) m_reset(i);
        check_all();
        cmp("async.total", a_tot, 0);
        cmp("async.busy",  a_busy, 1);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            res_valid = ($urandom_range(0, 1) == 1);
            res_pass  = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
